// File: rtl/mult64_pkg.sv
// Shared widths and types for the 64x64 pipelined multiplier.
package mult64_pkg;

    localparam int unsigned DATA_W  = 64;
    localparam int unsigned PROD_W  = 128;
    localparam int unsigned HALF_W  = 32;
    localparam int unsigned LATENCY = 4;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [HALF_W-1:0] half_t;
    typedef logic [PROD_W-1:0] prod_t;

endpackage

// File: rtl/mul_half_pp.sv
// Registered W x W unsigned partial-product multiplier with enable, clear and reset.
module mul_half_pp
    import mult64_pkg::*;
#(
    parameter int unsigned W = HALF_W
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           clr_i,
    input  logic           en_i,
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    output logic [2*W-1:0] p_o
);

    localparam int unsigned PW = 2 * W;

    logic [PW-1:0] p_d;
    logic [PW-1:0] p_q;

    always_comb begin
        p_d = PW'(a_i) * PW'(b_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            p_q <= '0;
        end else if (clr_i) begin
            p_q <= '0;
        end else if (en_i) begin
            p_q <= p_d;
        end
    end

    assign p_o = p_q;

endmodule

// File: rtl/multiplier_64b_pipe.sv
// Four-rank pipelined unsigned WIDTH x WIDTH multiplier with stall and clear.
// Optional valid tracking is enabled by defining MULT64_VALID_EN.
module multiplier_64b_pipe
    import mult64_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W
) (
    input  logic                 iClk,
    input  logic                 iRst,
    input  logic                 iEn,
    input  logic                 iClr,
    input  logic [WIDTH-1:0]     iData0,
    input  logic [WIDTH-1:0]     iData1,
`ifdef MULT64_VALID_EN
    input  logic                 iValid,
    output logic                 oValid,
`endif
    output logic [2*WIDTH-1:0]   oData
);

    localparam int unsigned HW  = WIDTH / 2;
    localparam int unsigned PW  = 2 * WIDTH;
    localparam int unsigned MW  = WIDTH + 1;

    if ((WIDTH % 2) != 0) begin : g_width_check
        $error("multiplier_64b_pipe: WIDTH must be even");
    end

    // Rank 1: operand capture
    logic [WIDTH-1:0] a_d, a_q;
    logic [WIDTH-1:0] b_d, b_q;

    always_comb begin
        a_d = iData0;
        b_d = iData1;
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            a_q <= '0;
            b_q <= '0;
        end else if (iClr) begin
            a_q <= '0;
            b_q <= '0;
        end else if (iEn) begin
            a_q <= a_d;
            b_q <= b_d;
        end
    end

    // Rank 2: four registered half-width partial products
    logic [WIDTH-1:0] pp_ll, pp_lh, pp_hl, pp_hh;

    mul_half_pp #(.W(HW)) u_pp_ll (
        .clk_i (iClk), .rst_i (iRst), .clr_i (iClr), .en_i (iEn),
        .a_i   (a_q[HW-1:0]), .b_i (b_q[HW-1:0]), .p_o (pp_ll)
    );

    mul_half_pp #(.W(HW)) u_pp_lh (
        .clk_i (iClk), .rst_i (iRst), .clr_i (iClr), .en_i (iEn),
        .a_i   (a_q[HW-1:0]), .b_i (b_q[WIDTH-1:HW]), .p_o (pp_lh)
    );

    mul_half_pp #(.W(HW)) u_pp_hl (
        .clk_i (iClk), .rst_i (iRst), .clr_i (iClr), .en_i (iEn),
        .a_i   (a_q[WIDTH-1:HW]), .b_i (b_q[HW-1:0]), .p_o (pp_hl)
    );

    mul_half_pp #(.W(HW)) u_pp_hh (
        .clk_i (iClk), .rst_i (iRst), .clr_i (iClr), .en_i (iEn),
        .a_i   (a_q[WIDTH-1:HW]), .b_i (b_q[WIDTH-1:HW]), .p_o (pp_hh)
    );

    // Rank 3: cross terms summed with carry kept; HH and LL never overlap so they concatenate
    logic [MW-1:0] mid_d, mid_q;
    logic [PW-1:0] edge_d, edge_q;

    always_comb begin
        mid_d  = MW'(pp_lh) + MW'(pp_hl);
        edge_d = {pp_hh, pp_ll};
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            mid_q  <= '0;
            edge_q <= '0;
        end else if (iClr) begin
            mid_q  <= '0;
            edge_q <= '0;
        end else if (iEn) begin
            mid_q  <= mid_d;
            edge_q <= edge_d;
        end
    end

    // Rank 4: final add; the true product always fits in PW bits
    logic [PW-1:0] prod_d, prod_q;

    always_comb begin
        prod_d = edge_q + (PW'(mid_q) << HW);
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            prod_q <= '0;
        end else if (iClr) begin
            prod_q <= '0;
        end else if (iEn) begin
            prod_q <= prod_d;
        end
    end

    assign oData = prod_q;

`ifdef MULT64_VALID_EN
    // Valid tag travels in lockstep with the data ranks
    logic [LATENCY-1:0] vld_d, vld_q;

    always_comb begin
        vld_d = {vld_q[LATENCY-2:0], iValid};
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            vld_q <= '0;
        end else if (iClr) begin
            vld_q <= '0;
        end else if (iEn) begin
            vld_q <= vld_d;
        end
    end

    assign oValid = vld_q[LATENCY-1];
`endif

endmodule

// File: tb/tb_multiplier_64b_pipe.sv
// Self-checking bench for multiplier_64b_pipe against a product delay-line model.
module tb_multiplier_64b_pipe;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en  = 1'b0;
    logic         clr = 1'b0;
    logic [63:0]  a   = '0;
    logic [63:0]  b   = '0;
    logic [127:0] dout;
    logic         vin = 1'b0;
`ifdef MULT64_VALID_EN
    logic         vout;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic [127:0] mdl [4];
    bit           mvl [4];

    always #5 clk = ~clk;

    multiplier_64b_pipe dut (
        .iClk   (clk),
        .iRst   (rst),
        .iEn    (en),
        .iClr   (clr),
        .iData0 (a),
        .iData1 (b),
`ifdef MULT64_VALID_EN
        .iValid (vin),
        .oValid (vout),
`endif
        .oData  (dout)
    );

    // One clock: model follows rst > clr > en, outputs sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        if (rst || clr) begin
            for (int i = 0; i < 4; i++) begin
                mdl[i] = '0;
                mvl[i] = 1'b0;
            end
        end else if (en) begin
            for (int i = 3; i > 0; i--) begin
                mdl[i] = mdl[i-1];
                mvl[i] = mvl[i-1];
            end
            mdl[0] = 128'(a) * 128'(b);
            mvl[0] = vin;
        end
        #1;
    endtask

    task automatic fill_random();
        en = 1'b1; rst = 1'b0; clr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a = {$urandom, $urandom} | 64'd1;
            b = {$urandom, $urandom} | 64'd1;
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; clr = 1'b0; a = 64'd5; b = 64'd7;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if (dout !== 128'd0) begin
                n_bad++;
                $display("FAIL reset_hold cyc=%0d got=%h exp=0", i, dout);
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if (dout !== ((i == 3) ? 128'd35 : 128'd0)) begin
                n_bad++;
                $display("FAIL reset_release cyc=%0d got=%h exp=%h", i, dout,
                         (i == 3) ? 128'd35 : 128'd0);
            end
        end
    endtask

    task automatic test_extremes();
        logic [63:0]  xa [3];
        logic [63:0]  xb [3];
        logic [127:0] xp [3];
        xa[0] = 64'hFFFF_FFFF_FFFF_FFFF; xb[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        xp[0] = 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001;
        xa[1] = 64'h8000_0000_0000_0000; xb[1] = 64'd2;
        xp[1] = 128'h0000_0000_0000_0001_0000_0000_0000_0000;
        xa[2] = 64'hDEAD_BEEF_1234_5678; xb[2] = 64'd0;
        xp[2] = 128'd0;
        en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i < 3) begin
                a = xa[i]; b = xb[i];
            end else begin
                a = 64'd0; b = 64'd0;
            end
            tick();
            if (i >= 3) begin
                n_cmp++;
                if (dout !== xp[i-3]) begin
                    n_bad++;
                    $display("FAIL extreme_%0d got=%h exp=%h", i - 3, dout, xp[i-3]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        en = 1'b1;
        for (int i = 0; i < 100; i++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            tick();
            n_cmp++;
            if (dout !== mdl[3]) begin
                n_bad++;
                $display("FAIL b2b cyc=%0d got=%h exp=%h", i, dout, mdl[3]);
            end
        end
    endtask

    task automatic test_stall();
        logic [127:0] held;
        int           seen;
        clr = 1'b1; tick(); clr = 1'b0;
        en = 1'b1; a = 64'd3; b = 64'd4;
        tick();
        a = 64'hFFFF_0000_FFFF_0000; b = 64'h1234_5678_9ABC_DEF0;
        en = 1'b0;
        held = dout;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if (dout !== held || dout !== mdl[3]) begin
                n_bad++;
                $display("FAIL stall_frozen cyc=%0d got=%h exp=%h", i, dout, held);
            end
        end
        en = 1'b1; a = 64'd0; b = 64'd0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (dout === 128'd12) seen++;
            n_cmp++;
            if ((i == 2) && (dout !== 128'd12)) begin
                n_bad++;
                $display("FAIL stall_resume got=%h exp=%h", dout, 128'd12);
            end
        end
        n_cmp++;
        if (seen !== 1) begin
            n_bad++;
            $display("FAIL stall_count got=%0d exp=1", seen);
        end
    endtask

    task automatic test_clear();
        for (int v = 0; v < 2; v++) begin
            fill_random();
            clr = 1'b1; en = (v == 0);
            tick();
            clr = 1'b0; en = 1'b1; a = 64'd0; b = 64'd0;
            n_cmp++;
            if (dout !== 128'd0) begin
                n_bad++;
                $display("FAIL clear_now en=%0d got=%h exp=0", 1 - v, dout);
            end
            for (int i = 0; i < 4; i++) begin
                tick();
                n_cmp++;
                if (dout !== 128'd0) begin
                    n_bad++;
                    $display("FAIL clear_flush en=%0d cyc=%0d got=%h exp=0", 1 - v, i, dout);
                end
            end
        end
        fill_random();
        rst = 1'b1; clr = 1'b1;
        tick();
        rst = 1'b0; clr = 1'b0; a = 64'd9; b = 64'd11;
        n_cmp++;
        if (dout !== 128'd0) begin
            n_bad++;
            $display("FAIL clr_rst got=%h exp=0", dout);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            a = 64'd0; b = 64'd0;
            n_cmp++;
            if (dout !== ((i == 3) ? 128'd99 : 128'd0)) begin
                n_bad++;
                $display("FAIL clr_rst_after cyc=%0d got=%h", i, dout);
            end
        end
    endtask

`ifdef MULT64_VALID_EN
    task automatic test_valid();
        clr = 1'b1; tick(); clr = 1'b0;
        en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            a = 64'(i + 1) * 64'h0100_0000_0003;
            b = 64'(i + 7);
            vin = (i % 2 == 0) && (i < 12);
            if (i == 8) en = 1'b0;
            if (i == 10) en = 1'b1;
            tick();
            n_cmp++;
            if (vout !== mvl[3] || dout !== mdl[3]) begin
                n_bad++;
                $display("FAIL valid cyc=%0d got=%b/%h exp=%b/%h", i, vout, dout, mvl[3], mdl[3]);
            end
        end
        vin = 1'b0;
    endtask
`endif

    initial begin
        for (int i = 0; i < 4; i++) begin
            mdl[i] = '0;
            mvl[i] = 1'b0;
        end
        #2;
        test_reset();
        test_extremes();
        test_back_to_back();
        test_stall();
        test_clear();
`ifdef MULT64_VALID_EN
        test_valid();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
